// File: rtl/pos_dac_pkg.sv
// pos_dac_pkg: shared FSM encoding and constants for the galvo DAC SPI serialiser.
package pos_dac_pkg;
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_LDAC} dac_state_t;
   localparam int DAC_BITS = 16;
   localparam logic [DAC_BITS-1:0] DAC_MIDSCALE = 16'h8000;
   localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;
endpackage

// File: rtl/pos_dac_spi_tick.sv
// spi_tick_gen: SCLK half-period divider; flags the last cycle of each low/high phase.
module spi_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_sys,
   input  logic sys_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   logic [CW-1:0] r_cnt;
   logic r_ph;
   logic w_end;
   assign w_end  = i_en && (r_cnt == CW'(CLK_DIV - 1));
   assign o_rise = w_end && !r_ph;
   assign o_fall = w_end && r_ph;
   always_ff @(posedge clk_sys)
      if (sys_rst || i_clr) begin
         r_cnt <= '0;
         r_ph  <= 1'b0;
      end else if (i_en) begin
         r_cnt <= w_end ? '0 : r_cnt + 1'b1;
         r_ph  <= r_ph ^ w_end;
      end
endmodule

// File: rtl/pos_dac_spi.sv
// pos_dac_spi: serialises position-loop DAC codes to a 16-bit SPI DAC with optional LDAC strobe.
module pos_dac_spi import pos_dac_pkg::*; #(
   parameter int CLK_DIV     = 2,
   parameter int CS_SETUP    = 1,
   parameter int CS_HOLD     = 1,
   parameter int MIN_CS_HIGH = 2,
   parameter int LDAC_EN     = 1,
   parameter int LDAC_W      = 1
) (
   input  logic                clk_sys,
   input  logic                sys_rst,
   input  logic [DAC_BITS-1:0] dac_data,
   input  logic                dac_valid,
   output logic                dac_busy,
   output logic [15:0]         overrun_cnt,
   output logic [DAC_BITS-1:0] last_sent,
   output logic                spi_cs_n,
   output logic                spi_sclk,
   output logic                spi_mosi,
   output logic                dac_ldac_n
);
   dac_state_t r_state, w_state;
   logic [DAC_BITS-1:0] r_pend, r_shreg, w_shreg, r_last, w_last;
   logic [15:0] r_cnt, w_cnt, r_ovr;
   logic [3:0] r_bit, w_bit;
   logic r_pend_vld, r_cs_n, w_cs_n, r_sclk, w_sclk, r_mosi, w_mosi, r_ldac_n, w_ldac_n, r_busy, w_busy;
   logic w_launch, w_rise, w_fall;

   spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_sys(clk_sys),
      .sys_rst(sys_rst),
      .i_clr  (w_launch),
      .i_en   (r_state == S_SHIFT),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // A launch in the same cycle consumes the old code, so the new one is not an overrun.
   always_ff @(posedge clk_sys)
      if (sys_rst) begin
         r_pend     <= DAC_MIDSCALE;
         r_pend_vld <= 1'b1;
         r_ovr      <= '0;
      end else begin
         if (dac_valid) r_pend <= dac_data;
         r_pend_vld <= dac_valid || (r_pend_vld && !w_launch);
         if (dac_valid && r_pend_vld && !w_launch && r_ovr != OVERRUN_MAX) r_ovr <= r_ovr + 16'd1;
      end

   always_ff @(posedge clk_sys)
      if (sys_rst) begin
         r_state  <= S_IDLE;
         r_shreg  <= DAC_MIDSCALE;
         r_last   <= DAC_MIDSCALE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_cs_n   <= 1'b1;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
         r_ldac_n <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_shreg  <= w_shreg;
         r_last   <= w_last;
         r_cnt    <= w_cnt;
         r_bit    <= w_bit;
         r_cs_n   <= w_cs_n;
         r_sclk   <= w_sclk;
         r_mosi   <= w_mosi;
         r_ldac_n <= w_ldac_n;
         r_busy   <= w_busy;
      end

   always_comb begin
      w_state  = r_state;
      w_shreg  = r_shreg;
      w_last   = r_last;
      w_cnt    = r_cnt + 16'd1;
      w_bit    = r_bit;
      w_cs_n   = r_cs_n;
      w_sclk   = r_sclk;
      w_mosi   = r_mosi;
      w_ldac_n = r_ldac_n;
      w_busy   = r_busy;
      w_launch = 1'b0;
      case (r_state)
         S_IDLE:
            if (r_pend_vld) begin
               w_launch = 1'b1;
               w_shreg  = r_pend;
               w_cs_n   = 1'b0;
               w_mosi   = r_pend[DAC_BITS-1];
               w_busy   = 1'b1;
               w_bit    = 4'(DAC_BITS - 1);
               w_cnt    = '0;
               w_state  = S_SETUP;
            end
         S_SETUP:
            if (r_cnt == 16'(CS_SETUP - 1)) begin
               w_cnt   = '0;
               w_state = S_SHIFT;
            end
         S_SHIFT: begin
            if (w_rise) w_sclk = 1'b1;
            if (w_fall) begin
               w_sclk = 1'b0;
               if (r_bit == 4'd0) begin
                  w_cnt   = '0;
                  w_state = S_HOLD;
               end else begin
                  w_bit  = r_bit - 4'd1;
                  w_mosi = r_shreg[r_bit - 4'd1];
               end
            end
         end
         S_HOLD:
            if (r_cnt == 16'(CS_HOLD - 1)) begin
               w_cs_n  = 1'b1;
               w_last  = r_shreg;
               w_cnt   = '0;
               w_state = S_GAP;
            end
         S_GAP:
            if (r_cnt == 16'(MIN_CS_HIGH - 1)) begin
               w_cnt    = '0;
               w_state  = LDAC_EN != 0 ? S_LDAC : S_IDLE;
               w_ldac_n = LDAC_EN == 0;
               w_busy   = LDAC_EN != 0;
            end
         S_LDAC:
            if (r_cnt == 16'(LDAC_W - 1)) begin
               w_ldac_n = 1'b1;
               w_busy   = 1'b0;
               w_state  = S_IDLE;
            end
         default: w_state = S_IDLE;
      endcase
   end

   assign dac_busy    = r_busy;
   assign overrun_cnt = r_ovr;
   assign last_sent   = r_last;
   assign spi_cs_n    = r_cs_n;
   assign spi_sclk    = r_sclk;
   assign spi_mosi    = r_mosi;
   assign dac_ldac_n  = r_ldac_n;
endmodule

// File: tb/tb_pos_dac_spi.sv
// tb_pos_dac_spi: default build plus a CLK_DIV=1/no-LDAC build, checked against a timeline model and an SPI frame decoder.
module tb_pos_dac_spi;
   typedef struct {
      int d, su, ho, mn, le, lw, t, free;
      bit vld, fresh;
      logic [15:0] pend, cur, last, ovr;
   } mdl_t;
   typedef struct {
      logic [2:0][15:0] d;
      int nw, off1, off2, ne, dov;
      logic [1:0][15:0] e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid [2];
   logic [15:0] data [2];
   logic busy [2], cs_n [2], sclk [2], mosi [2], ldac_n [2];
   logic [15:0] ovr [2], last [2];
   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   mdl_t m [2];
   bit ok [2];
   logic [15:0] rxq [$];
   vec_t tbl [5];
   int exp_ovr;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pos_dac_spi u_dut0 (
      .clk_sys(clk), .sys_rst(rst), .dac_data(data[0]), .dac_valid(valid[0]),
      .dac_busy(busy[0]), .overrun_cnt(ovr[0]), .last_sent(last[0]),
      .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .dac_ldac_n(ldac_n[0])
   );
   pos_dac_spi #(.CLK_DIV(1), .LDAC_EN(0)) u_dut1 (
      .clk_sys(clk), .sys_rst(rst), .dac_data(data[1]), .dac_valid(valid[1]),
      .dac_busy(busy[1]), .overrun_cnt(ovr[1]), .last_sent(last[1]),
      .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .dac_ldac_n(ldac_n[1])
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Expected pins for cycle c, derived from the time of the last frame launch.
   function automatic logic [36:0] predict(mdl_t x, int c);
      int L, P, k, nb;
      bit csl, bsy, ldl, sck, mo;
      L = x.su + 32 * x.d + x.ho;
      P = L + x.mn + (x.le != 0 ? x.lw : 0);
      k = c - x.t - 1 - x.su;
      nb = 32 * x.d;
      csl = c > x.t && c <= x.t + L;
      bsy = c > x.t && c <= x.t + P;
      ldl = x.le != 0 && c > x.t + L + x.mn && c <= x.t + P;
      sck = k >= 0 && k < nb && (k % (2 * x.d)) >= x.d;
      if (x.fresh) mo = 1'b0;
      else if (k < 0) mo = x.cur[15];
      else if (k < nb) mo = x.cur[15 - k / (2 * x.d)];
      else mo = x.cur[0];
      return {!csl, sck, mo, !ldl, bsy, x.ovr, x.last};
   endfunction

   function automatic mdl_t step(mdl_t x, logic r, logic v, logic [15:0] dd, int c);
      int L, P;
      if (r) begin
         x.t = -1000000; x.free = c + 1; x.vld = 1; x.pend = 16'h8000;
         x.ovr = 16'h0; x.last = 16'h8000; x.fresh = 1;
         return x;
      end
      L = x.su + 32 * x.d + x.ho;
      P = L + x.mn + (x.le != 0 ? x.lw : 0);
      if (c == x.t + L) x.last = x.cur;
      if (c >= x.free && x.vld) begin
         x.t = c; x.free = c + P + 1; x.cur = x.pend; x.fresh = 0; x.vld = 0;
      end
      if (v) begin
         if (x.vld && x.ovr != 16'hFFFF) x.ovr = x.ovr + 16'd1;
         x.pend = dd; x.vld = 1;
      end
      return x;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ok[i])
            chk(i == 0 ? "pins_dut0" : "pins_dut1",
                64'({cs_n[i], sclk[i], mosi[i], ldac_n[i], busy[i], ovr[i], last[i]}), 64'(predict(m[i], cyc)));
         m[i] = step(m[i], rst, valid[i], data[i], cyc);
         ok[i] = ok[i] | rst;
      end
      if (n_fail > 200) begin
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
         $finish;
      end
   end

   // Independent frame decoder on the default build's pins.
   logic prev_cs = 1'b1, prev_sclk = 1'b0, in_fr = 1'b0, gap_bad = 1'b0;
   int lowc = 0, nbits = 0, last_rise = -1;
   logic [15:0] code = '0;
   always @(negedge clk) begin
      if (rst) in_fr = 1'b0;
      else if (!cs_n[0] && prev_cs) begin
         in_fr = 1'b1; lowc = 0; nbits = 0; code = '0; gap_bad = 1'b0; last_rise = -1;
      end
      if (in_fr) begin
         if (!cs_n[0]) lowc++;
         if (sclk[0] && !prev_sclk) begin
            code = {code[14:0], mosi[0]};
            nbits++;
            if (last_rise >= 0 && cyc - last_rise != 4) gap_bad = 1'b1;
            last_rise = cyc;
         end
         if (cs_n[0] && !prev_cs) begin
            in_fr = 1'b0;
            chk("cs_low_width", 64'(lowc), 64'd66);
            chk("sclk_rise_count", 64'(nbits), 64'd16);
            chk("sclk_period_4", 64'(gap_bad), 64'd0);
            rxq.push_back(code);
         end
      end
      prev_cs = cs_n[0];
      prev_sclk = sclk[0];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(int i, logic [15:0] d);
      valid[i] = 1'b1;
      data[i] = d;
      tick();
      valid[i] = 1'b0;
   endtask

   task automatic settle();
      repeat (160) tick();
   endtask

   function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic [15:0] c, int nw, int o1, int o2,
                               logic [15:0] e0, logic [15:0] e1, int dov);
      vec_t v;
      v.d = {c, b, a}; v.nw = nw; v.off1 = o1; v.off2 = o2;
      v.ne = 2; v.e = {e1, e0}; v.dov = dov;
      return v;
   endfunction

   initial begin
      int wn;
      tbl[0] = mk(16'hA5C3, 16'h1234, 16'h5678, 3, 10, 3, 16'hA5C3, 16'h5678, 1);
      tbl[1] = mk(16'hFFFF, 16'h0001, 16'h0000, 2, 1, 0, 16'hFFFF, 16'h0001, 0);
      tbl[2] = mk(16'h1111, 16'h2222, 16'h3333, 3, 1, 5, 16'h1111, 16'h3333, 1);
      tbl[3] = mk(16'h0000, 16'hFFFF, 16'h0000, 2, 80, 0, 16'h0000, 16'hFFFF, 0);
      tbl[4] = mk(16'h7FFF, 16'h8001, 16'h4000, 3, 2, 1, 16'h7FFF, 16'h4000, 1);
      m[0] = '{d: 2, su: 1, ho: 1, mn: 2, le: 1, lw: 1, default: 0};
      m[1] = '{d: 1, su: 1, ho: 1, mn: 2, le: 0, lw: 1, default: 0};
      for (int i = 0; i < 2; i++) begin
         valid[i] = 1'b0;
         data[i] = '0;
         ok[i] = 1'b0;
      end
      repeat (3) tick();
      for (int i = 0; i < 2; i++)
         chk("reset_state", 64'({cs_n[i], sclk[i], mosi[i], ldac_n[i], busy[i], ovr[i], last[i]}),
             64'({5'b10010, 16'h0000, 16'h8000}));
      rst = 1'b0;
      // Midscale frame after reset.
      for (int k = 0; k < 200 && rxq.size() < 1; k++) tick();
      chk("reset_frame_count", 64'(rxq.size()), 64'd1);
      chk("reset_frame_code", 64'(rxq.size() > 0 ? rxq[0] : 16'hxxxx), 64'h8000);
      settle();
      chk("reset_last_sent", 64'(last[0]), 64'h8000);
      chk("reset_overrun", 64'(ovr[0]), 64'd0);
      // Launch latency from an idle, empty pending register.
      rxq.delete();
      wn = cyc;
      write(0, 16'hA5C3);
      for (int k = 0; k < 10 && cs_n[0]; k++) tick();
      chk("cs_fall_latency", 64'(cyc - wn), 64'd2);
      settle();
      chk("latency_frame", 64'(rxq.size() > 0 ? rxq[0] : 16'hxxxx), 64'hA5C3);
      chk("latency_last_sent", 64'(last[0]), 64'hA5C3);
      exp_ovr = 0;
      for (int r = 0; r < 5; r++) begin
         rxq.delete();
         write(0, tbl[r].d[0]);
         repeat (tbl[r].off1 - 1) tick();
         write(0, tbl[r].d[1]);
         if (tbl[r].nw > 2) begin
            repeat (tbl[r].off2 - 1) tick();
            write(0, tbl[r].d[2]);
         end
         settle();
         exp_ovr += tbl[r].dov;
         chk("vec_frame_count", 64'(rxq.size()), 64'(tbl[r].ne));
         for (int j = 0; j < tbl[r].ne; j++)
            chk("vec_frame_code", 64'(j < rxq.size() ? rxq[j] : 16'hxxxx), 64'(tbl[r].e[j]));
         chk("vec_overrun", 64'(ovr[0]), 64'(exp_ovr));
         chk("vec_last_sent", 64'(last[0]), 64'(tbl[r].e[tbl[r].ne - 1]));
      end
      // Reset landing on the first cycle of bit 7 aborts the frame.
      rxq.delete();
      write(0, 16'h3C3C);
      repeat (34) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_pins", 64'({cs_n[0], sclk[0], ldac_n[0], busy[0]}), 64'b1010);
      chk("abort_overrun", 64'(ovr[0]), 64'd0);
      settle();
      chk("abort_frame_count", 64'(rxq.size()), 64'd1);
      chk("abort_midscale", 64'(rxq.size() > 0 ? rxq[0] : 16'hxxxx), 64'h8000);
      // Random traffic on both builds.
      for (int k = 0; k < 3000; k++) begin
         valid[0] = $urandom_range(0, 15) == 0;
         data[0] = 16'($urandom);
         valid[1] = $urandom_range(0, 7) == 0;
         data[1] = 16'($urandom);
         tick();
      end
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      settle();
      // Continuous writes on the fast build drive the overrun counter into saturation.
      for (int k = 0; k < 67600; k++) begin
         valid[1] = 1'b1;
         data[1] = 16'($urandom);
         tick();
      end
      valid[1] = 1'b0;
      repeat (5) tick();
      chk("overrun_saturated", 64'(ovr[1]), 64'hFFFF);
      chk("ldac_idle_fast_build", 64'(ldac_n[1]), 64'd1);
      settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pos_dac_spi.md
Name: pos_dac_spi

Overview:
Downstream stage of the position PID loop. Takes each 16-bit offset-binary DAC code the loop produces and serialises it to the galvo driver's external 16-bit SPI DAC. Frames are MSB first; SCLK idles low and MOSI is sampled by the DAC on SCLK rising edges. An optional active-low LDAC strobe follows each frame. A single-entry pending register decouples loop rate from SPI rate: the newest code wins, and displaced codes are counted.

Parameters:
CLK_DIV, 2, clk_sys cycles per SCLK half-period (>=1)
CS_SETUP, 1, clk_sys cycles from cs_n fall to first SCLK low phase (>=1)
CS_HOLD, 1, clk_sys cycles from last SCLK fall to cs_n rise (>=1)
MIN_CS_HIGH, 2, minimum clk_sys cycles cs_n stays high between frames (>=1)
LDAC_EN, 1, 1 = generate ldac_n pulse after each frame
LDAC_W, 1, ldac_n low width in clk_sys cycles (>=1)

Ports:
clk_sys  in  1  system clock; all logic single-domain on rising edge
sys_rst  in  1  synchronous, active-high reset
dac_data  in  16  DAC code (offset binary, 0x8000 = midscale)
dac_valid  in  1  one-cycle strobe; dac_data is valid this cycle
dac_busy  out  1  high from frame launch until return to IDLE
overrun_cnt  out  16  saturating count of pending codes overwritten before send
last_sent  out  16  code of the most recently completed frame
spi_cs_n  out  1  DAC chip select, active low
spi_sclk  out  1  serial clock, idles low
spi_mosi  out  1  serial data, MSB first
dac_ldac_n  out  1  load strobe, active low

Behaviour:
- Reset, while sys_rst=1 and in the cycle after: spi_cs_n=1, spi_sclk=0, spi_mosi=0, dac_ldac_n=1, dac_busy=0, overrun_cnt=0, last_sent=0x8000. Reset also loads pend=0x8000 with pend_vld=1, so a midscale frame is sent automatically after reset. Reset asserted mid-frame aborts it immediately to these values; no partial LDAC is issued.
- Pending register: dac_valid=1 writes pend<=dac_data and pend_vld<=1.
- Overrun: if pend_vld=1 and pend is not being consumed in the same cycle, the code is overwritten and overrun_cnt increments, saturating at 0xFFFF. If a launch consumes pend in the same cycle, the new code stays pending and overrun_cnt is unchanged.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP, LDAC.
- IDLE: if pend_vld, load shreg<=pend, clear pend_vld, cs_n<=0, mosi<=pend[15], dac_busy<=1, go to SETUP.
- Latency: dac_valid in cycle N while IDLE with pend empty gives spi_cs_n low from cycle N+2.
- SETUP: hold for CS_SETUP cycles, sclk=0, then go to SHIFT.
- SHIFT: 16 bits. Each bit is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1. On each falling edge (except after bit 0), mosi advances to the next lower bit. A 4-bit bit counter and a divider counter drive this. After bit 0's high phase, sclk<=0 and go to HOLD.
- HOLD: CS_HOLD cycles, then cs_n<=1, last_sent<=shreg snapshot, go to GAP.
- GAP: MIN_CS_HIGH cycles, then go to LDAC if LDAC_EN, else to IDLE with dac_busy<=0.
- LDAC: ldac_n=0 for LDAC_W cycles, then ldac_n<=1, dac_busy<=0, go to IDLE.
- spi_cs_n low duration is exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles, which is 66 at defaults.
- Frame period to IDLE at defaults: 66 + 2 + 1 = 69 cycles. The next launch can start in the first IDLE cycle.
- dac_data is captured only on dac_valid. Changes during a frame never alter the frame in flight.
- All outputs are registered, with no combinational path from inputs to SPI pins.

Decomposition:
- Shared package pos_dac_pkg: FSM state enum, DAC_MIDSCALE=16'h8000, DAC_BITS=16, OVERRUN_MAX=16'hFFFF.
- One natural sub-module: spi_tick_gen. It is the CLK_DIV half-period counter emitting rise/fall enables, clearable at frame launch. Everything else stays in pos_dac_spi.

Test Plan:
1. Release reset with no stimulus: a frame of 0x8000 is sent; mosi reads 1 then fifteen 0s on sclk rises; cs_n is low for 66 cycles; ldac_n pulses low for 1 cycle; last_sent=0x8000; overrun_cnt=0.
2. After idle, dac_valid with 0xA5C3 at cycle N: cs_n falls at N+2; 16 rising edges capture 0xA5C3 MSB first; each SCLK period is 4 cycles; last_sent=0xA5C3 after cs_n rises.
3. Mid-frame, dac_valid with 0x1234 then 0x5678 three cycles later: overrun_cnt=1; the next frame sends 0x5678; 0x1234 is never sent; the gap between cs_n rise and the next cs_n fall is at least MIN_CS_HIGH+LDAC_W+1 cycles.
4. dac_valid with 0x0001 in the same cycle IDLE launches a pending 0xFFFF: 0xFFFF is sent first, then 0x0001; overrun_cnt is unchanged.
5. sys_rst asserted at bit 7 of a frame: the next cycle has cs_n=1, sclk=0, ldac_n=1, busy=0; after release a midscale frame is sent.
6. Build with LDAC_EN=0 and CLK_DIV=1, driving dac_valid on every cycle: ldac_n stays 1; frame period is 1+32+1+2=36 cycles; overrun_cnt saturates at 0xFFFF with no wrap (force the counter near max).
